// File: rtl/result_select_stage_pkg.sv
// Shared definitions for the result select stage: word width, writeback
// source indices and the select-width helpers used by the stage and its bus.
package result_select_stage_pkg;

  localparam int WORD_W  = 32;
  localparam int MIN_SRC = 2;
  localparam int MAX_SRC = 16;

  // Writeback source indices used when this stage sits in front of WB
  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_PC8  = 2'd2,
    WB_SRC_HILO = 2'd3
  } wb_src_e;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Select field width: never narrower than one bit
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/result_select_stage_if.sv
// Valid/ready bus of the result select stage: input beat with flattened
// sources and encoded select, output beat with error flags.
interface result_select_stage_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4
);
  import result_select_stage_pkg::*;

  localparam int SEL_W = sel_width(NUM_SRC);

  logic                       in_valid;
  logic                       in_ready;
  logic [SEL_W-1:0]           in_sel;
  logic [NUM_SRC*WIDTH-1:0]   in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       out_err;
  logic                       err_sticky;

  // Upstream producer and downstream consumer view
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err, err_sticky
  );

  // The select stage itself
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err, err_sticky
  );

endinterface

// File: rtl/result_select_stage_skid_reg.sv
// Generic 2-entry skid buffer: an output register (OR) backed by a skid
// register (SK). in_ready depends only on SK occupancy, so there is no
// combinational path from out_ready back to the producer.
module skid_reg #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  logic             r_or_valid;
  logic [WIDTH-1:0] r_or_data;
  logic             r_sk_valid;
  logic [WIDTH-1:0] r_sk_data;

  logic w_accept;
  logic w_drain;

  assign w_accept = i_in_valid && !r_sk_valid;
  assign w_drain  = r_or_valid && i_out_ready;

  // OR refills from SK first (oldest beat), then from the input; a beat
  // arriving while OR is stuck lands in SK and closes in_ready next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
    end else begin
      if (!r_or_valid || w_drain) begin
        if (r_sk_valid) begin
          r_or_data  <= r_sk_data;
          r_or_valid <= 1'b1;
          r_sk_valid <= 1'b0;
        end else if (w_accept) begin
          r_or_data  <= i_in_data;
          r_or_valid <= 1'b1;
        end else begin
          r_or_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_sk_data  <= i_in_data;
        r_sk_valid <= 1'b1;
      end
    end
  end

  assign o_in_ready  = !r_sk_valid;
  assign o_out_valid = r_or_valid;
  assign o_out_data  = r_or_data;

endmodule

// File: rtl/result_select_stage.sv
// N-way result selector with registered output and valid/ready flow control.
// The selected source (or zero plus an error flag for an out-of-range index)
// is pushed through a 2-entry skid buffer so stalls never drop or repeat
// a result. Legal NUM_SRC range is 2..16.
module result_select_stage
  import result_select_stage_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int NUM_SRC = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  result_select_stage_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_SRC);
  // Table covers every encodable index so the lookup needs no range compare
  localparam int TAB_N = 1 << SEL_W;

  logic [WIDTH:0] w_tab [TAB_N];
  logic [WIDTH:0] w_sel_payload;
  logic [WIDTH:0] w_out_payload;
  logic           w_in_ready;
  logic           w_out_valid;
  logic           r_err_sticky;

  // Legal indices map to their source; unused codes map to {err=1, data=0}.
  // When NUM_SRC is a power of two the error branch never elaborates.
  generate
    for (genvar gi = 0; gi < TAB_N; gi++) begin : g_tab
      if (gi < NUM_SRC) begin : g_src
        assign w_tab[gi] = {1'b0, bus.in_data[gi*WIDTH +: WIDTH]};
      end else begin : g_oor
        assign w_tab[gi] = {1'b1, {WIDTH{1'b0}}};
      end
    end
  endgenerate

  assign w_sel_payload = w_tab[bus.in_sel];

  skid_reg #(
    .WIDTH (WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (bus.in_valid),
    .o_in_ready  (w_in_ready),
    .i_in_data   (w_sel_payload),
    .o_out_valid (w_out_valid),
    .i_out_ready (bus.out_ready),
    .o_out_data  (w_out_payload)
  );

  // Sticky error: any accepted out-of-range beat latches it until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (bus.in_valid && w_in_ready && w_sel_payload[WIDTH]) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_err    = w_out_payload[WIDTH];
  assign bus.out_data   = w_out_payload[WIDTH-1:0];
  assign bus.err_sticky = r_err_sticky;

endmodule
